mips_mc_control_v2: RTL and testbench

Multi-cycle MIPS control FSM, second generation. Adds a synchronous reset and a memory ready/request handshake with wait states. Adds a wait-timeout trap, a wider ALU op set (andi/ori/slti), bne, and jal. Drives the same multi-cycle datapath; RegDst, MemtoReg and ALUOp are widened.

---
 rtl/mips_mc_control_v2_if.sv | 40 ++++
 rtl/mips_mc_control_v2.sv | 228 ++++++++++++++++++++++
 tb/tb_mips_mc_control_v2.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mc_control_v2_if.sv
// Control-to-datapath bundle for the multi-cycle MIPS controller.
// master: controller side (reads opcode/mem_ready, drives strobes/selects).
// slave:  datapath/memory side (drives opcode/mem_ready, reads strobes/selects).
interface mips_mc_control_v2_if #(
    parameter int OPCODE_W = 6
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                mem_req;
    logic                IorD;
    logic                MemWrite;
    logic                IRWrite;
    logic                PCWrite;
    logic                Branch;
    logic                BranchNE;
    logic                ALUSrcA;
    logic                RegWrite;
    logic [1:0]          PCSrc;
    logic [1:0]          ALUSrcB;
    logic [2:0]          ALUOp;
    logic [1:0]          RegDst;
    logic [1:0]          MemtoReg;
    logic                exception;
    logic [1:0]          exc_cause;
    logic [3:0]          state_dbg;

    modport master (
        input  opcode, mem_ready,
        output mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, BranchNE,
               ALUSrcA, RegWrite, PCSrc, ALUSrcB, ALUOp, RegDst, MemtoReg,
               exception, exc_cause, state_dbg
    );

    modport slave (
        output opcode, mem_ready,
        input  mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, BranchNE,
               ALUSrcA, RegWrite, PCSrc, ALUSrcB, ALUOp, RegDst, MemtoReg,
               exception, exc_cause, state_dbg
    );
endinterface

// File: rtl/mips_mc_control_v2.sv
// Multi-cycle MIPS control FSM with memory wait states, wait-timeout trap and sticky cause.
// Latency: Moore outputs registered from next state; IRWrite/PCWrite(FETCH)/MemWrite gated by mem_ready.
// Backpressure: FETCH/MEMRD/MEMWR hold until mem_ready; WAIT_MAX stalled cycles trap to the vector.
// Ports: clk, reset (sync, active-high, forces all outputs 0), bus (master modport of the _if).
// Optional macro ILLEGAL_TRAP_EN: undefined opcodes trap with cause 01 instead of acting as NOP.
module mips_mc_control_v2 #(
    parameter int         OPCODE_W     = 6,
    parameter int         WAIT_MAX     = 15,     // 1..255
    parameter int         CNT_W        = 8,      // 2^CNT_W > WAIT_MAX
    parameter logic [1:0] TRAP_VEC_SEL = 2'b11
) (
    input  logic clk,
    input  logic reset,
    mips_mc_control_v2_if.master bus
);

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_SLTI  = OPCODE_W'(10);
    localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(12);
    localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(13);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(35);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(43);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
        S_BRANCH = 4'd8,  S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_JUMP  = 4'd11,
        S_JAL    = 4'd12, S_TRAP   = 4'd13
    } state_t;

    // Registered control word. *_rdy fields still need mem_ready before they
    // become visible strobes; pcwrite is the unconditional PC write.
    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       memwrite_rdy;
        logic       irwrite_rdy;
        logic       pcwrite_rdy;
        logic       pcwrite;
        logic       branch;
        logic       branchne;
        logic       alusrca;
        logic       regwrite;
        logic [1:0] pcsrc;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       exception;
    } ctl_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]       cause_q, cause_d;
    ctl_t             ctl_q;
    logic             timeout;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

    // Opcode is the IR, stable from DECODE until the next fetch completes, so
    // sampling it when entering BRANCH/IEXEC matches a live decode.
    function automatic ctl_t decode(input state_t s, input logic [OPCODE_W-1:0] op);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req     = 1'b1;
                c.irwrite_rdy = 1'b1;
                c.pcwrite_rdy = 1'b1;
                c.alusrcb     = 2'b01;
            end
            S_DECODE:  c.alusrcb = 2'b11;
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 2'b01;
            end
            S_MEMWR: begin
                c.mem_req      = 1'b1;
                c.iord         = 1'b1;
                c.memwrite_rdy = 1'b1;
            end
            S_EXEC: begin
                c.alusrca = 1'b1;
                c.aluop   = 3'b010;
            end
            S_ALUWB: begin
                c.regwrite = 1'b1;
                c.regdst   = 2'b01;
            end
            S_BRANCH: begin
                c.alusrca  = 1'b1;
                c.aluop    = 3'b001;
                c.pcsrc    = 2'b01;
                c.branch   = (op == OP_BEQ);
                c.branchne = (op == OP_BNE);
            end
            S_IEXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                case (op)
                    OP_ANDI: c.aluop = 3'b011;
                    OP_ORI:  c.aluop = 3'b100;
                    OP_SLTI: c.aluop = 3'b101;
                    default: c.aluop = 3'b000;
                endcase
            end
            S_IWB:     c.regwrite = 1'b1;
            S_JUMP: begin
                c.pcwrite = 1'b1;
                c.pcsrc   = 2'b10;
            end
            S_JAL: begin
                c.pcwrite  = 1'b1;
                c.pcsrc    = 2'b10;
                c.regwrite = 1'b1;
                c.regdst   = 2'b10;
                c.memtoreg = 2'b10;
            end
            S_TRAP: begin
                c.exception = 1'b1;
                c.pcwrite   = 1'b1;
                c.pcsrc     = TRAP_VEC_SEL;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        cause_d    = cause_q;
        timeout    = is_mem_state(state_q) && !bus.mem_ready && (wait_cnt_q == CNT_LAST);

        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:                     state_d = S_MEMADR;
                    OP_RTYPE:                         state_d = S_EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXEC;
                    OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
                    OP_J:                             state_d = S_JUMP;
                    OP_JAL:                           state_d = S_JAL;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
                        cause_d = 2'b01;
`else
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_IEXEC:  state_d = S_IWB;
            default:  state_d = S_FETCH;   // MEMWB, ALUWB, IWB, BRANCH, JUMP, JAL, TRAP
        endcase

        // mem_ready on the last allowed cycle already kept timeout low above.
        if (timeout) begin
            state_d = S_TRAP;
            cause_d = 2'b10;
        end

        if (bus.mem_ready || (is_mem_state(state_d) && (state_d != state_q)))
            wait_cnt_d = '0;
        else if (is_mem_state(state_q))
            wait_cnt_d = wait_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            cause_q    <= 2'b00;
            ctl_q      <= decode(S_FETCH, bus.opcode);
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            cause_q    <= cause_d;
            ctl_q      <= decode(state_d, bus.opcode);
        end
    end

    // Reset blanks every output, including the debug state and sticky cause.
    logic live;
    assign live = !reset;

    assign bus.mem_req   = live & ctl_q.mem_req;
    assign bus.IorD      = live & ctl_q.iord;
    assign bus.MemWrite  = live & ctl_q.memwrite_rdy & bus.mem_ready;
    assign bus.IRWrite   = live & ctl_q.irwrite_rdy & bus.mem_ready;
    assign bus.PCWrite   = live & (ctl_q.pcwrite | (ctl_q.pcwrite_rdy & bus.mem_ready));
    assign bus.Branch    = live & ctl_q.branch;
    assign bus.BranchNE  = live & ctl_q.branchne;
    assign bus.ALUSrcA   = live & ctl_q.alusrca;
    assign bus.RegWrite  = live & ctl_q.regwrite;
    assign bus.PCSrc     = {2{live}} & ctl_q.pcsrc;
    assign bus.ALUSrcB   = {2{live}} & ctl_q.alusrcb;
    assign bus.ALUOp     = {3{live}} & ctl_q.aluop;
    assign bus.RegDst    = {2{live}} & ctl_q.regdst;
    assign bus.MemtoReg  = {2{live}} & ctl_q.memtoreg;
    assign bus.exception = live & ctl_q.exception;
    assign bus.exc_cause = {2{live}} & cause_q;
    assign bus.state_dbg = {4{live}} & state_q;

endmodule

// File: tb/tb_mips_mc_control_v2.sv
// Scoreboard bench: the driver walks instructions through a path-level model,
// pushing the expected output word for every cycle; a negedge monitor compares.
module tb_mips_mc_control_v2;

    localparam int WAIT_MAX = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_mc_control_v2_if #(.OPCODE_W(6)) bus ();

    mips_mc_control_v2 #(
        .OPCODE_W(6), .WAIT_MAX(WAIT_MAX), .CNT_W(8), .TRAP_VEC_SEL(2'b11)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [3:0] state_dbg;
        logic       mem_req;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       branchne;
        logic       alusrca;
        logic       regwrite;
        logic [1:0] pcsrc;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       exception;
        logic [1:0] exc_cause;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle_no = 0;
    bit [1:0] exc_m = 2'b00;   // model of the sticky cause

    // Expected outputs of one cycle, straight from the per-state output table.
    function automatic obs_t expect_of(input int st, input bit rdy, input logic [5:0] op);
        obs_t o;
        o = '0;
        o.state_dbg = 4'(st);
        o.exc_cause = exc_m;
        case (st)
            0:  begin o.mem_req = 1; o.irwrite = rdy; o.pcwrite = rdy; o.alusrcb = 2'b01; end
            1:  o.alusrcb = 2'b11;
            2:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
            3:  begin o.mem_req = 1; o.iord = 1; end
            4:  begin o.regwrite = 1; o.memtoreg = 2'b01; end
            5:  begin o.mem_req = 1; o.iord = 1; o.memwrite = rdy; end
            6:  begin o.alusrca = 1; o.aluop = 3'b010; end
            7:  begin o.regwrite = 1; o.regdst = 2'b01; end
            8:  begin o.alusrca = 1; o.aluop = 3'b001; o.pcsrc = 2'b01;
                      o.branch = (op == 4); o.branchne = (op == 5); end
            9:  begin o.alusrca = 1; o.alusrcb = 2'b10;
                      o.aluop = (op == 12) ? 3'b011 : (op == 13) ? 3'b100 :
                                (op == 10) ? 3'b101 : 3'b000; end
            10: o.regwrite = 1;
            11: begin o.pcwrite = 1; o.pcsrc = 2'b10; end
            12: begin o.pcwrite = 1; o.pcsrc = 2'b10; o.regwrite = 1;
                      o.regdst = 2'b10; o.memtoreg = 2'b10; end
            13: begin o.exception = 1; o.pcwrite = 1; o.pcsrc = 2'b11; end
            default: o = '0;
        endcase
        return o;
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show in it.
    task automatic cyc(input int st, input bit rst, input bit rdy, input logic [5:0] op);
        obs_t e;
        reset         = rst;
        bus.mem_ready = rdy;
        bus.opcode    = op;
        e = rst ? obs_t'('0) : expect_of(st, rdy, op);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // A memory access stalled for w cycles. Returns 0 if it timed out (TRAP issued).
    task automatic mem_phase(input int st, input int w, input logic [5:0] op, output bit ok);
        int n;
        n = (w < WAIT_MAX) ? w : WAIT_MAX;
        for (int i = 0; i < n; i++) cyc(st, 1'b0, 1'b0, op);
        if (w >= WAIT_MAX) begin
            exc_m = 2'b10;
            cyc(13, 1'b0, 1'($urandom_range(0, 1)), op);
            ok = 1'b0;
        end else begin
            cyc(st, 1'b0, 1'b1, op);
            ok = 1'b1;
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        bit ok;
        bit r;
        mem_phase(0, fw, 6'($urandom_range(0, 63)), ok);
        if (!ok) return;
        r = 1'($urandom_range(0, 1));
        cyc(1, 1'b0, r, op);
        case (op)
            6'd35: begin
                cyc(2, 1'b0, 1'($urandom_range(0, 1)), op);
                mem_phase(3, mw, op, ok);
                if (ok) cyc(4, 1'b0, 1'($urandom_range(0, 1)), op);
            end
            6'd43: begin
                cyc(2, 1'b0, 1'($urandom_range(0, 1)), op);
                mem_phase(5, mw, op, ok);
            end
            6'd0: begin
                cyc(6, 1'b0, 1'($urandom_range(0, 1)), op);
                cyc(7, 1'b0, 1'($urandom_range(0, 1)), op);
            end
            6'd8, 6'd10, 6'd12, 6'd13: begin
                cyc(9, 1'b0, 1'($urandom_range(0, 1)), op);
                cyc(10, 1'b0, 1'($urandom_range(0, 1)), op);
            end
            6'd4, 6'd5: cyc(8, 1'b0, 1'($urandom_range(0, 1)), op);
            6'd2:       cyc(11, 1'b0, 1'($urandom_range(0, 1)), op);
            6'd3:       cyc(12, 1'b0, 1'($urandom_range(0, 1)), op);
            default: begin
`ifdef ILLEGAL_TRAP_EN
                exc_m = 2'b01;
                cyc(13, 1'b0, 1'($urandom_range(0, 1)), op);
`endif
            end
        endcase
    endtask

    function automatic int rand_wait();
        int p;
        p = $urandom_range(0, 19);
        if (p == 0) return WAIT_MAX;
        if (p == 1) return WAIT_MAX - 1;
        return $urandom_range(0, 3);
    endfunction

    // Monitor: compare each cycle's outputs against the queued expectation.
    initial begin
        obs_t a, e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.state_dbg = bus.state_dbg;  a.mem_req  = bus.mem_req;
                a.iord      = bus.IorD;       a.memwrite = bus.MemWrite;
                a.irwrite   = bus.IRWrite;    a.pcwrite  = bus.PCWrite;
                a.branch    = bus.Branch;     a.branchne = bus.BranchNE;
                a.alusrca   = bus.ALUSrcA;    a.regwrite = bus.RegWrite;
                a.pcsrc     = bus.PCSrc;      a.alusrcb  = bus.ALUSrcB;
                a.aluop     = bus.ALUOp;      a.regdst   = bus.RegDst;
                a.memtoreg  = bus.MemtoReg;   a.exception = bus.exception;
                a.exc_cause = bus.exc_cause;
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got state=%0d word=%h, expected state=%0d word=%h",
                             cycle_no, a.state_dbg, a, e.state_dbg, e);
                end
                cycle_no++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    localparam int NLEGAL = 12;
    logic [5:0] legal [NLEGAL] = '{6'd35, 6'd43, 6'd0, 6'd8, 6'd12, 6'd13,
                                   6'd10, 6'd4, 6'd5, 6'd2, 6'd3, 6'd35};

    initial begin
        bit ok;
        logic [5:0] op;
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode = 6'd0;
        @(posedge clk);
        #1;
        // Reset held two cycles with mem_ready high: everything reads 0.
        cyc(0, 1'b1, 1'b1, 6'd0);
        cyc(0, 1'b1, 1'b1, 6'd0);
        exc_m = 2'b00;

        // Directed: lw with 3 stall cycles, sw that times out, the I-type set,
        // bne, jal, an undefined opcode, beq, R-type, j, boundary waits.
        run_instr(6'd35, 0, 3);
        run_instr(6'd43, 0, 100);
        run_instr(6'd8, 0, 0);
        run_instr(6'd12, 1, 0);
        run_instr(6'd13, 0, 0);
        run_instr(6'd10, 2, 0);
        run_instr(6'd5, 0, 0);
        run_instr(6'd3, 0, 0);
        run_instr(6'd63, 0, 0);
        run_instr(6'd4, 0, 0);
        run_instr(6'd0, 0, 0);
        run_instr(6'd2, 0, 0);
        run_instr(6'd35, 0, WAIT_MAX - 1);   // ready on the last allowed cycle
        run_instr(6'd43, WAIT_MAX - 1, 0);
        run_instr(6'd0, WAIT_MAX, 0);        // fetch timeout

        // Reset in the middle of a load wait: access aborted, cause cleared.
        mem_phase(0, 0, 6'd0, ok);
        cyc(1, 1'b0, 1'b0, 6'd35);
        cyc(2, 1'b0, 1'b0, 6'd35);
        cyc(3, 1'b0, 1'b0, 6'd35);
        cyc(3, 1'b0, 1'b0, 6'd35);
        cyc(3, 1'b1, 1'b1, 6'd35);
        exc_m = 2'b00;
        run_instr(6'd43, 0, 1);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
            else op = legal[$urandom_range(0, NLEGAL - 1)];
            run_instr(op, rand_wait(), rand_wait());
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
